// File: rtl/loader_pkg.sv
// Shared definitions for the index loader.
// Holds the FSM state encoding and the default buffer geometry used by the top.
package loader_pkg;

   localparam int LOADER_DEPTH = 8;
   localparam int IDX_W        = 3;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/pb_edge_sync.sv
// Push-button conditioner: 2-flop synchronizer followed by a rising-edge
// detector. One press (of any length of at least one clock) gives exactly
// one single-cycle pulse.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   pb    : raw, asynchronous button level
//   pulse : one-cycle high pulse per rising edge of the synchronized level
module pb_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic pulse
);

   // sr[0], sr[1] form the synchronizer; sr[2] is the delayed copy used for the
   // edge compare.
   logic [2:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr <= {sr[1:0], pb};
      end
   end

   assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/index_loader.sv
// Index loader: captures switch values, one per debounced button press, into a
// small buffer and then streams them in write order to the decoder over a
// valid/ready handshake.
//   clk, rst   : system clock, asynchronous active-high reset
//   sw         : index value captured on a pb_load press
//   pb_load    : raw button, rising edge writes sw into the buffer
//   pb_start   : raw button, starts a partial burst or restarts from DONE
//   out_valid  : entry available (STREAM only)
//   out_data   : current entry mem[rd_ptr]
//   out_last   : final entry of the burst
//   out_ready  : decoder accepts the entry
//   count      : entries stored
//   busy       : high in STREAM
//
// state  | meaning
// FILL   | collecting entries from pb_load presses
// STREAM | presenting mem[rd_ptr] until the last entry is accepted
// DONE   | burst finished, count holds burst length, waiting for pb_start
import loader_pkg::*;

module index_loader #(
   parameter int DEPTH = LOADER_DEPTH,
   parameter int W     = IDX_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [W-1:0]               sw,
   input  logic                       pb_load,
   input  logic                       pb_start,
   output logic                       out_valid,
   output logic [W-1:0]               out_data,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic           load_p;
   logic           start_p;
   state_t         state;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [W-1:0]   mem [DEPTH];
   logic           write_en;
   logic [CW-1:0]  count_nx;
   logic [CW-1:0]  count_m1;

   pb_edge_sync u_sync_load (
      .clk   (clk),
      .rst   (rst),
      .pb    (pb_load),
      .pulse (load_p)
   );

   pb_edge_sync u_sync_start (
      .clk   (clk),
      .rst   (rst),
      .pb    (pb_start),
      .pulse (start_p)
   );

   assign write_en = (state == FILL) && load_p && (count < CW'(DEPTH));
   // Count after this edge's write; used so a simultaneous start sees the new
   // entry, including the empty-buffer case.
   assign count_nx = count + CW'(write_en);
   assign count_m1 = count - CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FILL;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         case (state)
            FILL: begin
               if (write_en) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  count  <= count_nx;
               end
               if ((count_nx == CW'(DEPTH)) || (start_p && (count_nx != '0))) begin
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (out_ready) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  if (out_last) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (start_p) begin
                  wr_ptr <= '0;
                  rd_ptr <= '0;
                  count  <= '0;
                  state  <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // Buffer contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[wr_ptr] <= sw;
      end
   end

   // All outputs decode registered state only; out_ready never reaches them.
   assign busy      = (state == STREAM);
   assign out_valid = busy;
   assign out_data  = mem[rd_ptr];
   assign out_last  = busy && ({1'b0, rd_ptr} == count_m1);

endmodule

// File: tb/tb_index_loader.sv
// Self-checking bench for index_loader. Loaded values are pushed into a
// scoreboard queue and popped by a monitor on every handshake; the beat that
// empties the queue must carry out_last.
module tb_index_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] sw;
   logic       pb_load;
   logic       pb_start;
   logic       out_valid;
   logic [2:0] out_data;
   logic       out_last;
   logic       out_ready;
   logic [3:0] count;
   logic       busy;

   logic       rdy;
   logic       bp_en;
   logic [1:0] ph = 2'd0;
   logic [3:0] bp_pat = 4'b1001;   // per-cycle ready pattern 1,0,0,1

   int         n_tests = 0;
   int         n_fail  = 0;
   int         hs_cnt  = 0;
   int         busy_cyc = 0;
   logic [7:0] dec     = 8'h00;
   logic [2:0] q[$];

   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [2:0] prev_data  = 3'd0;
   logic       prev_last  = 1'b0;

   always #5 clk = ~clk;

   assign out_ready = bp_en ? bp_pat[ph] : rdy;

   always @(posedge clk) ph <= ph + 2'd1;

   index_loader dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .pb_load   (pb_load),
      .pb_start  (pb_start),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .count     (count),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: scoreboard pop on handshake, hold check under backpressure.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (busy) busy_cyc++;
         if (prev_valid && !prev_ready && out_valid) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            dec = dec ^ (8'h80 >> out_data);
            if (q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               chk("beat_last", out_last, (q.size() == 1));
               chk("beat_data", out_data, q.pop_front());
            end
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic press(input logic ld, input logic st, input logic [2:0] v, input int hold);
      sw       = v;
      pb_load  = ld;
      pb_start = st;
      repeat (hold) @(negedge clk);
      pb_load  = 1'b0;
      pb_start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic load(input logic [2:0] v);
      q.push_back(v);
      press(1'b1, 1'b0, v, 2);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 0);
      chk({tag, "_drained"}, q.size(), 0);
   endtask

   task automatic restart();
      press(1'b0, 1'b1, 3'd0, 2);
      chk("restart_count", count, 0);
      chk("restart_busy", busy, 0);
   endtask

   initial begin
      logic [2:0] full_vals [8] = '{3'd3, 3'd4, 3'd7, 3'd2, 3'd3, 3'd5, 3'd0, 3'd2};
      int         hs0;
      int         bc0;
      logic [7:0] dec0;

      rst = 1'b1; sw = 3'd0; pb_load = 1'b0; pb_start = 1'b0;
      rdy = 1'b1; bp_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // start with empty buffer is ignored
      press(1'b0, 1'b1, 3'd0, 2);
      chk("empty_start_busy", busy, 0);
      chk("empty_start_count", count, 0);

      // full-buffer burst, automatic STREAM entry
      hs0 = hs_cnt; bc0 = busy_cyc; dec0 = dec;
      for (int i = 0; i < 8; i++) load(full_vals[i]);
      wait_idle("full_done");
      chk("full_hs", hs_cnt - hs0, 8);
      chk("full_cycles", busy_cyc - bc0, 8);
      chk("full_decoder", dec ^ dec0, 8'h8D);
      chk("full_count_done", count, 8);

      // load in DONE ignored, then restart
      press(1'b1, 1'b0, 3'd6, 2);
      chk("done_load_count", count, 8);
      chk("done_load_busy", busy, 0);
      restart();

      // partial burst
      load(3'd6);
      load(3'd1);
      chk("partial_count", count, 2);
      chk("partial_wait", busy, 0);
      hs0 = hs_cnt;
      press(1'b0, 1'b1, 3'd0, 2);
      wait_idle("partial_done");
      chk("partial_hs", hs_cnt - hs0, 2);
      chk("partial_count_done", count, 2);
      restart();

      // simultaneous load and start on empty buffer
      q.push_back(3'd5);
      press(1'b1, 1'b1, 3'd5, 2);
      wait_idle("simul_done");
      chk("simul_count", count, 1);
      restart();

      // held load writes exactly one entry
      q.push_back(3'd4);
      press(1'b1, 1'b0, 3'd4, 10);
      chk("held_count", count, 1);
      press(1'b0, 1'b1, 3'd0, 2);
      wait_idle("held_done");
      restart();

      // backpressure with random data, plus a load during STREAM
      rdy = 1'b0;
      hs0 = hs_cnt;
      for (int i = 0; i < 7; i++) load(3'($urandom_range(0, 7)));
      bp_en = 1'b1;
      load(3'($urandom_range(0, 7)));
      press(1'b1, 1'b0, 3'd3, 2);
      chk("stream_load_busy", busy, 1);
      chk("stream_load_count", count, 8);
      wait_idle("bp_done");
      bp_en = 1'b0;
      chk("bp_hs", hs_cnt - hs0, 8);
      chk("bp_count", count, 8);
      restart();

      // reset mid-stream after beat 3
      rdy = 1'b0;
      hs0 = hs_cnt;
      for (int i = 0; i < 8; i++) load(3'(7 - i));
      chk("pre_rst_busy", busy, 1);
      rdy = 1'b1;
      repeat (3) @(negedge clk);
      rdy = 1'b0;
      chk("pre_rst_hs", hs_cnt - hs0, 3);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_last", out_last, 0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rdy = 1'b1;
      hs0 = hs_cnt;
      for (int i = 0; i < 8; i++) load(3'($urandom_range(0, 7)));
      wait_idle("post_rst_done");
      chk("post_rst_hs", hs_cnt - hs0, 8);
      chk("post_rst_count", count, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/index_loader.md
# index_loader

Upstream feeder for the one-hot XOR decoder stage. It captures 3-bit index values from board switches, one per debounced push-button press, into an 8-entry buffer. It then streams the stored entries in write order to the decoder over a valid/ready handshake. This replaces the decoder's hard-wired memory preload with user-entered data.

## Interface
Parameters:
- `DEPTH`, 8: buffer entries; power of two ≥ 2.
- `W`, 3: index width; `DEPTH == 2**W` in the default build.

Ports:
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sw`  in  W  index value to capture; held stable by the user.
- `pb_load`  in  1  raw push-button; a rising edge captures `sw`.
- `pb_start`  in  1  raw push-button; a rising edge starts streaming early (partial buffer) or restarts from DONE.
- `out_valid`  out  1  entry available to the decoder.
- `out_data`  out  W  current entry, `mem[rd_ptr]`.
- `out_last`  out  1  high with the final entry of the burst.
- `out_ready`  in  1  decoder accepts the entry.
- `count`  out  $clog2(DEPTH)+1  entries currently stored.
- `busy`  out  1  high in STREAM.

## Operation
- Both buttons pass through a 2-flop synchronizer and a rising-edge detector, giving a 1-cycle pulse per press: `load_p`, `start_p`.
- The FSM has three states: FILL, STREAM and DONE. Reset state is FILL.
- FILL:
  - On `load_p` with `count < DEPTH`: write `mem[wr_ptr] <= sw`, then increment `wr_ptr` and `count`.
  - When `count` reaches DEPTH (the write of the last entry), go to STREAM on the same edge.
  - On `start_p` with `count > 0`: go to STREAM. With `count == 0`, `start_p` is ignored.
  - If `load_p` and `start_p` arrive on the same edge: perform the write first, then go to STREAM with the new count, including the count 0→1 case.
- STREAM:
  - `out_valid` = 1, `out_data` = `mem[rd_ptr]`, `out_last` = (`rd_ptr == count-1`).
  - On `out_valid && out_ready`, increment `rd_ptr`. If `out_last` was high, go to DONE.
  - When `out_ready` = 0, `out_data` and `out_last` hold stable.
  - `load_p` is ignored.
- DONE:
  - `out_valid` = 0. `count` keeps the burst length.
  - On `start_p`: clear `wr_ptr`, `rd_ptr` and `count`, then go to FILL. `load_p` is ignored.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `count` is one bit wider so that it can represent DEPTH.
- Reset at any time, including mid-stream:
  - `count`, both pointers, the synchronizers, `out_valid`, `out_last` and `busy` go to 0; state goes to FILL.
  - Buffer contents are not cleared and their values are don't-care.
  - `out_data` after reset shows `mem[0]` (don't-care).

## Timing
- A press is recognised when `pb_*` is sampled high at edge k. The edge pulse is active during the cycle after edge k+1, so the write or transition happens at edge k+2.
- A press shorter than one clock period may be missed. This is acceptable.
- Holding a button produces a single pulse.
- Transition latency:
  - STREAM begins the cycle after the edge that wrote entry DEPTH, or the cycle after `start_p`.
  - The first `out_valid` is high in that cycle.
- Throughput is one entry per cycle while `out_ready` = 1.
- `out_valid`, `out_data` and `out_last` depend only on registered state. There is no combinational path from `out_ready`.

## Structure
- Shared package `loader_pkg`:
  - state enum: FILL, STREAM, DONE.
  - constants: `LOADER_DEPTH` = 8, `IDX_W` = 3.
- Sub-module `pb_edge_sync`: 2-flop synchronizer plus rising-edge pulse, with async active-high reset. Instantiated twice, once per button.
- Buffer: register array sized DEPTH×W, with no reset on its contents.

## Test plan
- Full-buffer burst:
  - Stimulus: load 3,4,7,2,3,5,0,2 via 8 presses, `out_ready` = 1.
  - Response: STREAM entered automatically; `out_data` sequence is 3,4,7,2,3,5,0,2 on consecutive cycles; `out_last` high only on the 8th; then DONE.
  - With the decoder attached, its final output is 8'h8D.
- Partial burst:
  - Stimulus: load 6,1, then press `pb_start`.
  - Response: 2 beats, 6 then 1; `out_last` on beat 2; `count` = 2 in DONE.
- Backpressure:
  - Stimulus: toggle `out_ready` 1,0,0,1,... during STREAM.
  - Response: `out_data` holds while not ready; no entry is skipped or repeated; exactly 8 handshakes occur.
- Corner presses:
  - `pb_start` with `count` = 0 is ignored (stays in FILL).
  - Simultaneous load (sw = 5) and start with `count` = 0 gives a 1-beat burst of 5 with `out_last` = 1.
  - A 10-cycle held `pb_load` writes exactly one entry.
- Ignored loads and restart:
  - Stimulus: press `pb_load` during STREAM and DONE.
  - Response: `count` unchanged.
  - `pb_start` in DONE gives FILL with `count` = 0; a new burst then works.
- Reset mid-stream:
  - Stimulus: assert `rst` after beat 3.
  - Response: immediately `out_valid` = 0, `count` = 0, state FILL.
  - After release, a fresh 8-entry load streams correctly from `rd_ptr` = 0.
